tmds_encoder: RTL and testbench

- Converts one 8-bit colour channel plus two control bits into a 10-bit TMDS character, per the DVI 1.0 8b/10b algorithm.
- Runs in the pixel clock domain and drives the 10-bit parallel input of the per-lane 10:1 OSERDES serializer.
- Three instances (B/G/R) form the encode stage of the HDMI transmitter; hsync/vsync ride on the blue lane's control bits.

---
 rtl/tmds_encoder_if.sv | 14 +
 rtl/tmds_encoder.sv | 160 ++++++++++++++++
 tb/tb_tmds_encoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if: per-lane pixel/control bundle into the TMDS encoder and the 10-bit character out.
// The master side is the video timing source; the slave side is the encoder.
interface tmds_encoder_if;
  logic       de;
  logic [7:0] din;
  logic       c0;
  logic       c1;
  logic       aux_en;
  logic [3:0] aux;
  logic [9:0] dout;

  modport master (output de, din, c0, c1, aux_en, aux, input dout);
  modport slave  (input de, din, c0, c1, aux_en, aux, output dout);
endinterface

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI 1.0 8b/10b TMDS encoder for one lane; capture, q_m and output stages (2-cycle latency).
// Define TMDS_TERC4_EN to add HDMI data-island TERC4 coding of aux when aux_en is set during blanking.
module tmds_encoder (
  input  logic          clk1x,
  input  logic          rst,
  tmds_encoder_if.slave bus
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimised word: XNOR chain for dense inputs, XOR chain otherwise; bit 8 records XOR.
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q;
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

`ifdef TMDS_TERC4_EN
  // Table is written with bit 0 leftmost, as in the HDMI tables, and reversed onto dout[9:0].
  function automatic logic [9:0] terc4(input logic [3:0] nib);
    logic [9:0] listed;
    logic [9:0] rev;
    case (nib)
      4'h0:    listed = 10'b1010011100;
      4'h1:    listed = 10'b1001100011;
      4'h2:    listed = 10'b1011100100;
      4'h3:    listed = 10'b1011100010;
      4'h4:    listed = 10'b0101110001;
      4'h5:    listed = 10'b0100011110;
      4'h6:    listed = 10'b0110001110;
      4'h7:    listed = 10'b0100111100;
      4'h8:    listed = 10'b1011001100;
      4'h9:    listed = 10'b0100111001;
      4'hA:    listed = 10'b0110011100;
      4'hB:    listed = 10'b1011000111;
      4'hC:    listed = 10'b1010001110;
      4'hD:    listed = 10'b1001110001;
      4'hE:    listed = 10'b0101100011;
      default: listed = 10'b1011000011;
    endcase
    for (int i = 0; i < 10; i++) rev[i] = listed[9-i];
    return rev;
  endfunction
`endif

  logic       cap_de, cap_c0, cap_c1;
  logic [7:0] cap_din;
  logic       qm_de, qm_c0, qm_c1;
  logic [8:0] qm_q;
  logic [9:0] dout_q, dout_nxt;
  logic [4:0] cnt_q, cnt_nxt;
  logic [3:0] n1q;
  logic [5:0] bal, cnt_ext, sum;

`ifdef TMDS_TERC4_EN
  logic       cap_aux_en, qm_aux_en;
  logic [3:0] cap_aux, qm_aux;

  always_ff @(posedge clk1x) begin
    if (rst) begin
      cap_aux_en <= 1'b0;
      cap_aux    <= '0;
      qm_aux_en  <= 1'b0;
      qm_aux     <= '0;
    end else begin
      cap_aux_en <= bus.aux_en;
      cap_aux    <= bus.aux;
      qm_aux_en  <= cap_aux_en;
      qm_aux     <= cap_aux;
    end
  end
`else
  logic unused_aux;
  assign unused_aux = ^{bus.aux_en, bus.aux};
`endif

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk1x) begin
    if (rst) begin
      cap_de  <= 1'b0;
      cap_c0  <= 1'b0;
      cap_c1  <= 1'b0;
      cap_din <= '0;
      qm_de   <= 1'b0;
      qm_c0   <= 1'b0;
      qm_c1   <= 1'b0;
      qm_q    <= '0;
      dout_q  <= CTRL_00;
      cnt_q   <= '0;
    end else begin
      cap_de  <= bus.de;
      cap_c0  <= bus.c0;
      cap_c1  <= bus.c1;
      cap_din <= bus.din;
      qm_de   <= cap_de;
      qm_c0   <= cap_c0;
      qm_c1   <= cap_c1;
      qm_q    <= transition_min(cap_din);
      dout_q  <= dout_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // NOTE: every variable of this block gets a default first so no path can infer a latch.
  always_comb begin
    dout_nxt = CTRL_00;
    cnt_nxt  = '0;
    n1q      = popcount8(qm_q[7:0]);
    bal      = {1'b0, n1q, 1'b0} - 6'd8;  // n1q - n0q, two's complement
    cnt_ext  = {cnt_q[4], cnt_q};
    sum      = cnt_ext;
    if (qm_de) begin
      if ((cnt_q == 5'd0) || (n1q == 4'd4)) begin
        dout_nxt = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        sum      = qm_q[8] ? (cnt_ext + bal) : (cnt_ext - bal);
      end else if (($signed(cnt_q) > 5'sd0 && n1q > 4'd4) ||
                   ($signed(cnt_q) < 5'sd0 && n1q < 4'd4)) begin
        dout_nxt = {1'b1, qm_q[8], ~qm_q[7:0]};
        sum      = cnt_ext + {4'b0000, qm_q[8], 1'b0} - bal;
      end else begin
        dout_nxt = {1'b0, qm_q[8], qm_q[7:0]};
        sum      = cnt_ext + bal - {4'b0000, ~qm_q[8], 1'b0};
      end
      cnt_nxt = sum[4:0];  // magnitude stays within 10, so the top bit is pure sign extension
    end
`ifdef TMDS_TERC4_EN
    else if (qm_aux_en) begin
      dout_nxt = terc4(qm_aux);
    end
`endif
    else begin
      case ({qm_c1, qm_c0})
        2'b00:   dout_nxt = CTRL_00;
        2'b01:   dout_nxt = CTRL_01;
        2'b10:   dout_nxt = CTRL_10;
        default: dout_nxt = CTRL_11;
      endcase
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed and random stimulus against an integer-arithmetic TMDS reference model.
// Expected characters are queued with the clock edge they must appear on; a monitor compares each edge.
`timescale 1ns/1ps
module tb_tmds_encoder;

  logic clk1x = 1'b0;
  logic rst   = 1'b1;

  tmds_encoder_if bus();
  tmds_encoder dut (.clk1x(clk1x), .rst(rst), .bus(bus));

  always #5 clk1x = ~clk1x;

  typedef struct {
    int         edge_no;
    logic [9:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   mon_edge = 0;
  int   m_cnt    = 0;

  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

`ifdef TMDS_TERC4_EN
  string terc4_listed [16] = '{
    "1010011100", "1001100011", "1011100100", "1011100010",
    "0101110001", "0100011110", "0110001110", "0100111100",
    "1011001100", "0100111001", "0110011100", "1011000111",
    "1010001110", "1001110001", "0101100011", "1011000011"};

  function automatic logic [9:0] terc4_ref(input logic [3:0] a);
    string      s;
    logic [9:0] v;
    s = terc4_listed[a];
    for (int i = 0; i < 10; i++) v[i] = (s[i] == "1");
    return v;
  endfunction
`endif

  // Reference character for one input set; updates the model's running disparity m_cnt.
  function automatic logic [9:0] ref_char(input logic de, input logic [7:0] din, input logic c1,
                                          input logic c0, input logic aux_en, input logic [3:0] aux);
    logic [8:0] qm;
    logic [9:0] res;
    int         ones, bal;
    bit         inv;
    if (de) begin
      ones  = $countones(din);
      inv   = (ones > 4) || (ones == 4 && din[0] == 1'b0);
      qm[0] = din[0];
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i] ^ inv;
      qm[8] = !inv;
      bal   = 2 * $countones(qm[7:0]) - 8;
      if (m_cnt == 0 || bal == 0) begin
        res   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        m_cnt = m_cnt + (qm[8] ? bal : -bal);
      end else if ((m_cnt > 0 && bal > 0) || (m_cnt < 0 && bal < 0)) begin
        res   = {1'b1, qm[8], ~qm[7:0]};
        m_cnt = m_cnt + 2 * int'(qm[8]) - bal;
      end else begin
        res   = {1'b0, qm[8], qm[7:0]};
        m_cnt = m_cnt + bal - 2 * int'(!qm[8]);
      end
      return res;
    end
    m_cnt = 0;
`ifdef TMDS_TERC4_EN
    if (aux_en) return terc4_ref(aux);
`endif
    return ctrl_tab[{c1, c0}];
  endfunction

  // Drive one cycle of stimulus for the next rising edge and queue what it must produce.
  task automatic step(input logic r, input logic de, input logic [7:0] din, input logic c1,
                      input logic c0, input logic aux_en, input logic [3:0] aux);
    int k;
    @(negedge clk1x);
    rst        = r;
    bus.de     = de;
    bus.din    = din;
    bus.c1     = c1;
    bus.c0     = c0;
    bus.aux_en = aux_en;
    bus.aux    = aux;
    k = mon_edge + 1;
    if (r) begin
      while (exp_q.size() > 0 && exp_q[$].edge_no >= k) void'(exp_q.pop_back());
      for (int i = 0; i < 3; i++) exp_q.push_back('{k + i, ctrl_tab[0]});
      m_cnt = 0;
    end else begin
      exp_q.push_back('{k + 2, ref_char(de, din, c1, c0, aux_en, aux)});
    end
  endtask

  task automatic ctrl(input logic c1, input logic c0);
    step(1'b0, 1'b0, 8'h00, c1, c0, 1'b0, 4'h0);
  endtask

  task automatic video(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk1x);
      mon_edge++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].edge_no <= mon_edge) begin
        e = exp_q.pop_front();
        total++;
        if (e.edge_no != mon_edge || bus.dout !== e.val) begin
          bad++;
          $display("FAIL dout at edge %0d (due edge %0d): got %b expected %b",
                   mon_edge, e.edge_no, bus.dout, e.val);
        end
      end
    end
  end

  initial begin : stimulus
    logic r, de, aux_en;
    logic [7:0] din;
    logic [3:0] aux;
    bus.de = 1'b1; bus.din = 8'hAA; bus.c0 = 1'b0; bus.c1 = 1'b0;
    bus.aux_en = 1'b0; bus.aux = 4'h0;

    // Reset held with live video on the inputs.
    repeat (3) step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 4'h0);

    // All four control codes back to back.
    ctrl(0, 0); ctrl(0, 1); ctrl(1, 0); ctrl(1, 1);

    // Disparity walk from a fresh control period.
    ctrl(0, 0); ctrl(0, 0);
    video(8'h00); video(8'h00); video(8'h00);

    // XNOR path, then control returns disparity to zero.
    ctrl(1, 1); video(8'hFF); ctrl(0, 0); video(8'hFF);

    // Reset in the middle of a zero-data run; the next character starts balanced.
    video(8'h00); video(8'h00);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0);
    video(8'h00); video(8'h00); video(8'h00);

    // Data-island nibbles (control codes when the TERC4 build option is absent).
    for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 8'h00, a[1], a[0], 1'b1, 4'(a));

    // Random traffic with occasional resets and extreme pixel values.
    for (int n = 0; n < 400; n++) begin
      r      = ($urandom_range(0, 63) == 0);
      de     = ($urandom_range(0, 3) != 0);
      aux_en = ($urandom_range(0, 1) == 1);
      aux    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       din = 8'h00;
        1:       din = 8'hFF;
        default: din = 8'($urandom_range(0, 255));
      endcase
      step(r, de, din, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aux_en, aux);
    end

    repeat (3) ctrl(0, 0);
    repeat (4) @(negedge clk1x);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d characters never appeared, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
